// File: rtl/pic_control_logic.sv
// Control stage of an 8259-style PIC: ICW/OCW write decode, init sequencing,
// two-pulse INTA handshake, INT generation and vector/status readback.
module pic_control_logic #(
  parameter logic [7:0] VEC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] isr_id,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic       int_out,
  output logic [7:0] mask,
  output logic       level_or_edge_flag,
  output logic       aeoi,
  output logic       eoi,
  output logic       rotate,
  output logic [1:0] intAcounter
);

  localparam int unsigned VEC_W = 5;
  localparam int unsigned CNT_W = 2;

  localparam logic [CNT_W-1:0] CNT_IDLE = 2'b00;
  localparam logic [CNT_W-1:0] CNT_ONE  = 2'b01;
  localparam logic [CNT_W-1:0] CNT_TWO  = 2'b10;

  typedef enum logic [2:0] {
    WAIT_ICW1,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_t;

  state_t             state_q, state_d;
  logic               wr_n_q, rd_n_q, inta_n_q;
  logic               sngl_q, sngl_d;
  logic               ic4_q, ic4_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [7:0]         mask_q, mask_d;
  logic               ltim_q, ltim_d;
  logic               aeoi_q, aeoi_d;
  logic               eoi_q, eoi_d;
  logic               rotate_q, rotate_d;
  logic               int_q, int_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_en_q, dout_en_d;

  logic wr_fall_c, inta_fall_c, inta_rise_c, read_c, ready_c;

  assign wr_fall_c   = wr_n_q & ~wr_n & ~cs_n;
  assign inta_fall_c = inta_n_q & ~inta_n;
  assign inta_rise_c = ~inta_n_q & inta_n;
  assign read_c      = ~cs_n & ~rd_n & ~rd_n_q;
  assign ready_c     = (state_q == READY);

  // Strobe sampling for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      inta_n_q <= 1'b1;
    end else begin
      wr_n_q   <= wr_n;
      rd_n_q   <= rd_n;
      inta_n_q <= inta_n;
    end
  end

  // State and control register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_ICW1;
      sngl_q    <= 1'b0;
      ic4_q     <= 1'b0;
      vec_q     <= VEC_RESET[7:3];
      mask_q    <= 8'hFF;
      ltim_q    <= 1'b0;
      aeoi_q    <= 1'b0;
      eoi_q     <= 1'b0;
      rotate_q  <= 1'b0;
      int_q     <= 1'b0;
      cnt_q     <= CNT_IDLE;
      dout_q    <= 8'h00;
      dout_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sngl_q    <= sngl_d;
      ic4_q     <= ic4_d;
      vec_q     <= vec_d;
      mask_q    <= mask_d;
      ltim_q    <= ltim_d;
      aeoi_q    <= aeoi_d;
      eoi_q     <= eoi_d;
      rotate_q  <= rotate_d;
      int_q     <= int_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  // Next-state: INTA handshake, INT, data bus, then write decode (ICW1 overrides)
  always_comb begin
    state_d   = state_q;
    sngl_d    = sngl_q;
    ic4_d     = ic4_q;
    vec_d     = vec_q;
    mask_d    = mask_q;
    ltim_d    = ltim_q;
    aeoi_d    = aeoi_q;
    eoi_d     = 1'b0;
    rotate_d  = rotate_q;
    int_d     = int_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;

    if (ready_c) begin
      case (cnt_q)
        CNT_IDLE: if (inta_fall_c) cnt_d = CNT_ONE;
        CNT_ONE:  if (inta_fall_c) cnt_d = CNT_TWO;
        CNT_TWO:  if (inta_rise_c) cnt_d = CNT_IDLE;
        default:  cnt_d = CNT_IDLE;
      endcase
    end

    // INT is only managed between INTA sequences
    if (cnt_q == CNT_IDLE) begin
      if (ready_c && inta_fall_c) begin
        int_d = 1'b0;
      end else if (!int_req) begin
        int_d = 1'b0;
      end else if (ready_c) begin
        int_d = 1'b1;
      end
    end

    // Vector phase has priority over CPU reads
    if (cnt_q == CNT_TWO && !inta_n) begin
      dout_d    = {vec_q, isr_id};
      dout_en_d = 1'b1;
    end else if (read_c && cnt_q == CNT_IDLE && inta_n) begin
      dout_d    = a0 ? mask_q : {4'b0000, int_req, isr_id};
      dout_en_d = 1'b1;
    end

    if (wr_fall_c) begin
      if (!a0 && din[4]) begin
        ltim_d   = din[3];
        sngl_d   = din[1];
        ic4_d    = din[0];
        mask_d   = 8'h00;
        aeoi_d   = 1'b0;
        rotate_d = 1'b0;
        int_d    = 1'b0;
        cnt_d    = CNT_IDLE;
        state_d  = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (a0) begin
            vec_d = din[7:3];
            if (!sngl_q)     state_d = WAIT_ICW3;
            else if (ic4_q)  state_d = WAIT_ICW4;
            else             state_d = READY;
          end
          WAIT_ICW3: if (a0) begin
            state_d = ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (a0) begin
            aeoi_d  = din[1];
            state_d = READY;
          end
          READY: begin
            if (a0) begin
              mask_d = din;
            end else if (din[4:3] == 2'b00) begin
              case (din[7:5])
                3'b001: eoi_d = 1'b1;
                3'b101: begin
                  eoi_d    = 1'b1;
                  rotate_d = 1'b1;
                end
                3'b100: rotate_d = 1'b1;
                3'b000: rotate_d = 1'b0;
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dout               = dout_q;
  assign dout_en            = dout_en_q;
  assign int_out            = int_q;
  assign mask               = mask_q;
  assign level_or_edge_flag = ltim_q;
  assign aeoi               = aeoi_q;
  assign eoi                = eoi_q;
  assign rotate             = rotate_q;
  assign intAcounter        = cnt_q;

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed bench for pic_control_logic; bus data checked through a scoreboard queue.
module tb_pic_control_logic;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, wr_n, rd_n, a0, inta_n, int_req;
  logic [7:0] din;
  logic [2:0] isr_id;
  logic [7:0] dout, mask;
  logic       dout_en, int_out, level_or_edge_flag, aeoi, eoi, rotate;
  logic [1:0] intAcounter;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned eoi_cnt = 0;
  logic [7:0]  sb_q[$];
  logic        dout_en_prev = 1'b0;

  pic_control_logic #(.VEC_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
    .din(din), .inta_n(inta_n), .int_req(int_req), .isr_id(isr_id),
    .dout(dout), .dout_en(dout_en), .int_out(int_out), .mask(mask),
    .level_or_edge_flag(level_or_edge_flag), .aeoi(aeoi), .eoi(eoi),
    .rotate(rotate), .intAcounter(intAcounter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each new dout_en assertion must match the oldest expected bus value
  always @(negedge clk) begin
    if (eoi === 1'b1) eoi_cnt++;
    if (dout_en === 1'b1 && !dout_en_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_dout: got %h expected none", dout);
      end else begin
        chk("dout", dout, sb_q.pop_front());
      end
    end
    dout_en_prev = (dout_en === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    cyc(1);
    cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
    cyc(2);
    wr_n = 1'b1; cs_n = 1'b1;
    cyc(2);
  endtask

  task automatic rd(input logic a, input logic [7:0] exp);
    sb_q.push_back(exp);
    cyc(1);
    cs_n = 1'b0; a0 = a; rd_n = 1'b0;
    cyc(3);
    rd_n = 1'b1; cs_n = 1'b1;
    cyc(2);
  endtask

  int unsigned e0;

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a0 = 1'b0;
    din = 8'h00; inta_n = 1'b1; int_req = 1'b0; isr_id = 3'd0;
    cyc(3);
    @(negedge clk);
    chk("rst_mask", mask, 8'hFF);
    chk("rst_dout_en", 8'(dout_en), 8'h00);
    chk("rst_int", 8'(int_out), 8'h00);
    chk("rst_cnt", 8'(intAcounter), 8'h00);
    chk("rst_flags", {4'b0, level_or_edge_flag, aeoi, eoi, rotate}, 8'h00);
    rst_n = 1'b1;

    // Test 1: ICW1/ICW2/ICW4 single mode
    wr(1'b0, 8'h13);
    @(negedge clk); chk("icw1_mask", mask, 8'h00);
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h03);
    @(negedge clk);
    chk("t1_ltim", 8'(level_or_edge_flag), 8'h00);
    chk("t1_aeoi", 8'(aeoi), 8'h01);

    // Test 2: INTA sequence with vector {01000,101}
    int_req = 1'b1; isr_id = 3'd5;
    cyc(3);
    @(negedge clk); chk("t2_int_up", 8'(int_out), 8'h01);
    inta_n = 1'b0; cyc(2);
    @(negedge clk);
    chk("t2_cnt1", 8'(intAcounter), 8'h01);
    chk("t2_int_down", 8'(int_out), 8'h00);
    cyc(1); inta_n = 1'b1; cyc(2);
    @(negedge clk); chk("t2_cnt1_hold", 8'(intAcounter), 8'h01);
    sb_q.push_back(8'h45);
    cyc(1); inta_n = 1'b0; cyc(3);
    @(negedge clk);
    chk("t2_cnt2", 8'(intAcounter), 8'h02);
    chk("t2_dout_en", 8'(dout_en), 8'h01);
    cyc(1); inta_n = 1'b1; cyc(1);
    @(negedge clk);
    chk("t2_cnt0", 8'(intAcounter), 8'h00);
    chk("t2_dout_en_off", 8'(dout_en), 8'h00);
    int_req = 1'b0;
    cyc(3);
    @(negedge clk); chk("t2_int_drop", 8'(int_out), 8'h00);

    // Test 3: OCW1 and readback
    wr(1'b1, 8'hA5);
    @(negedge clk); chk("t3_mask", mask, 8'hA5);
    rd(1'b1, 8'hA5);
    rd(1'b0, 8'h05);

    // Test 4: OCW2 EOI / rotate
    e0 = eoi_cnt;
    wr(1'b0, 8'h20);
    @(negedge clk);
    chk("t4_eoi_20", 8'(eoi_cnt - e0), 8'h01);
    chk("t4_rot_20", 8'(rotate), 8'h00);
    e0 = eoi_cnt;
    wr(1'b0, 8'hA0);
    @(negedge clk);
    chk("t4_eoi_A0", 8'(eoi_cnt - e0), 8'h01);
    chk("t4_rot_A0", 8'(rotate), 8'h01);
    e0 = eoi_cnt;
    wr(1'b0, 8'h00);
    @(negedge clk);
    chk("t4_eoi_00", 8'(eoi_cnt - e0), 8'h00);
    chk("t4_rot_00", 8'(rotate), 8'h00);

    // Test 5: cascade mode with ICW3 consumed, stray OCW-like write ignored
    wr(1'b0, 8'h18);
    e0 = eoi_cnt;
    wr(1'b0, 8'h20);
    @(negedge clk); chk("t5_ignored_w", 8'(eoi_cnt - e0), 8'h00);
    wr(1'b1, 8'h08);
    wr(1'b1, 8'hFF);
    @(negedge clk);
    chk("t5_icw3_mask", mask, 8'h00);
    chk("t5_ltim", 8'(level_or_edge_flag), 8'h01);
    chk("t5_aeoi", 8'(aeoi), 8'h00);
    wr(1'b1, 8'h3C);
    @(negedge clk); chk("t5_ready_mask", mask, 8'h3C);

    // Test 6: async reset mid-INTA
    int_req = 1'b1; isr_id = 3'd2;
    cyc(3);
    inta_n = 1'b0; cyc(2);
    @(negedge clk); chk("t6_cnt1", 8'(intAcounter), 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_cnt_rst", 8'(intAcounter), 8'h00);
    chk("t6_dout_en_rst", 8'(dout_en), 8'h00);
    chk("t6_mask_rst", mask, 8'hFF);
    chk("t6_int_rst", 8'(int_out), 8'h00);
    inta_n = 1'b1; int_req = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    chk("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
